spi_frame_slave: RTL and testbench
==================================

Name: spi_frame_slave

Overview:
- SPI slave endpoint (mode 0, MSB first) that receives fixed 24-bit command frames {cmd, addr, payload} from an SPI master and presents them as parallel fields with a one-cycle valid strobe.
- Optionally shifts a 24-bit response frame out on miso in the same transaction (full duplex).
- Runs entirely on sysclk. The SPI lines are asynchronous inputs, oversampled through synchronizers.
- Sits between the board SPI pins and the LED/brightness register logic.

Parameters:
- FRAME_WIDTH, 24, total bits per frame; must equal CMD_BITS+ADDR_BITS+PAYLOAD_BITS.
- CMD_BITS, 8, command field width (frame bits [23:16]).
- ADDR_BITS, 8, address field width (frame bits [15:8]).
- PAYLOAD_BITS, 8, payload field width (frame bits [7:0]).

Ports:
- sysclk  in  1  system clock; must be at least 4x sclk (125 MHz vs 26 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master, idle low.
- cs  in  1  chip select, active low.
- mosi  in  1  serial data from master.
- slv_tx_enb  in  1  enables the response frame for the next transaction.
- i_slv_frame  in  FRAME_WIDTH  response frame to shift out on miso.
- miso  out  1  serial data to master.
- o_cmd  out  CMD_BITS  last received command.
- o_addr  out  ADDR_BITS  last received address.
- o_payload  out  PAYLOAD_BITS  last received payload.
- rx_dv  out  1  one-sysclk pulse: new frame is on o_cmd/o_addr/o_payload.
- o_shift_reg_debug  out  FRAME_WIDTH  receive shift register.
- o_serial_debug  out  1  synchronized mosi.
- o_bit_rx_cnt_debug  out  5  received bit count.
- o_debug_stage  out  3  FSM state encoding.

Behaviour:
- Synchronization: sclk, cs and mosi each pass through a 2-FF synchronizer, then a registered edge detector (rise/fall of sclk, fall/rise of cs).
- Protocol:
  - Frame starts on a cs falling edge.
  - mosi is sampled on sclk rising edges and shifted in MSB first.
  - miso changes on sclk falling edges.
- FSM, o_debug_stage encoding:
  - IDLE=3'd0: cs high. On cs fall:
    - clear the bit counter and shift register;
    - load the tx shift register with i_slv_frame if slv_tx_enb=1, else all zeros;
    - drive its MSB on miso;
    - go to RX.
  - RX=3'd1: on each sclk rise, shift_reg <= {shift_reg[22:0], mosi_sync} and count++. On each sclk fall, shift the tx register left and drive the new MSB on miso. When count reaches 24, go to DONE.
  - DONE=3'd2:
    - o_cmd <= shift_reg[23:16], o_addr <= shift_reg[15:8], o_payload <= shift_reg[7:0];
    - rx_dv=1 for exactly this one cycle;
    - go to WAIT_CS.
  - WAIT_CS=3'd3: ignore sclk; on cs rise go to IDLE.
- Latency: rx_dv asserts 3-4 sysclk cycles after the raw 24th sclk rising edge. Output fields are valid in the same cycle as rx_dv and are held until the next completed frame.
- cs rises while in RX (short frame):
  - abort and go to IDLE;
  - no rx_dv;
  - o_cmd/o_addr/o_payload unchanged.
- Extra sclk edges after bit 24 (in WAIT_CS) are ignored. miso holds 0 after the tx register empties.
- miso is 0 whenever the FSM is in IDLE; it is never tri-stated.
- slv_tx_enb and i_slv_frame are sampled only at frame start; changes mid-frame have no effect.
- cs falling edge seen in any state other than IDLE: ignored.
- Reset (asynchronous, any time including mid-frame):
  - FSM to IDLE;
  - all shift registers, counter, synchronizers, o_cmd, o_addr, o_payload, rx_dv and miso to 0;
  - synchronizer stage for cs resets to 1 (idle).

Optional Feature:
- Macro SPI_SLAVE_DEBUG_EN.
- Defined: the o_*_debug ports and o_debug_stage reflect the internal shift register, synchronized mosi, bit counter and FSM state every cycle.
- Undefined: these ports remain in the port list but are tied to constant 0. No functional change to the other outputs.

Test Plan:
- Master sends 0x81A1D1, slv_tx_enb=0 -> single rx_dv pulse; o_cmd=0x81, o_addr=0xA1, o_payload=0xD1; miso reads 0x000000.
- Back-to-back frame 0x01020A after the first -> o_cmd=0x01, o_addr=0x02, o_payload=0x0A; exactly one rx_dv per frame.
- slv_tx_enb=1, i_slv_frame=0x00000A, master sends 0x010905 -> o_cmd=0x01, o_addr=0x09, o_payload=0x05; master captures 0x00000A on miso.
- cs raised after 12 bits of 0xFFFFFF, then full frame 0x123456 -> no rx_dv for the aborted frame; fields stay at the previous values, then become 0x12/0x34/0x56.
- rst_n pulsed low mid-frame -> all outputs 0 and FSM IDLE immediately; next full frame 0xA5C33C received correctly.
- 26 sclk pulses in one cs window with frame 0xABCDEF -> one rx_dv; fields 0xAB/0xCD/0xEF; extra pulses ignored.

Source files
------------

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave: receives fixed command/address/payload frames on sysclk-oversampled pins
// and optionally returns a response frame on miso. Debug ports are live only with SPI_SLAVE_DEBUG_EN.
module spi_frame_slave #(
    parameter int FRAME_WIDTH  = 24,
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    input  logic                    slv_tx_enb,
    input  logic [FRAME_WIDTH-1:0]  i_slv_frame,
    output logic                    miso,
    output logic [CMD_BITS-1:0]     o_cmd,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_payload,
    output logic                    rx_dv,
    output logic [FRAME_WIDTH-1:0]  o_shift_reg_debug,
    output logic                    o_serial_debug,
    output logic [4:0]              o_bit_rx_cnt_debug,
    output logic [2:0]              o_debug_stage
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_DONE    = 3'd2,
        ST_WAIT_CS = 3'd3
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(FRAME_WIDTH - 1);

    logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic cs_meta_r, cs_sync_r, cs_prev_r;
    logic mosi_meta_r, mosi_sync_r;
    logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

    state_t state_r, next_state_s;

    logic [FRAME_WIDTH-1:0]  shift_r;
    logic [FRAME_WIDTH-1:0]  tx_r;
    logic [4:0]              bit_cnt_r;
    logic                    miso_r;
    logic                    rx_dv_r;
    logic [CMD_BITS-1:0]     cmd_r;
    logic [ADDR_BITS-1:0]    addr_r;
    logic [PAYLOAD_BITS-1:0] payload_r;

    // Two-stage synchronizers plus previous-value registers for edge detection
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= cs;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
    assign cs_fall_s   = ~cs_sync_r & cs_prev_r;
    assign cs_rise_s   = cs_sync_r & ~cs_prev_r;

    // FSM state register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an early cs rise wins over a coincident final sclk edge
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    next_state_s = ST_RX;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RX: begin
                if (cs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else if (sclk_rise_s && (bit_cnt_r == LAST_BIT)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RX;
                end
            end
            ST_DONE: begin
                next_state_s = ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                // Level check so a cs release during the DONE cycle is not lost
                if (cs_sync_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_CS;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Receive/transmit datapath and registered frame outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= {FRAME_WIDTH{1'b0}};
            tx_r      <= {FRAME_WIDTH{1'b0}};
            bit_cnt_r <= 5'd0;
            miso_r    <= 1'b0;
            rx_dv_r   <= 1'b0;
            cmd_r     <= {CMD_BITS{1'b0}};
            addr_r    <= {ADDR_BITS{1'b0}};
            payload_r <= {PAYLOAD_BITS{1'b0}};
        end else begin
            rx_dv_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    miso_r <= 1'b0;
                    if (cs_fall_s) begin
                        shift_r   <= {FRAME_WIDTH{1'b0}};
                        bit_cnt_r <= 5'd0;
                        tx_r      <= slv_tx_enb ? i_slv_frame : {FRAME_WIDTH{1'b0}};
                        miso_r    <= slv_tx_enb & i_slv_frame[FRAME_WIDTH-1];
                    end
                end
                ST_RX: begin
                    if (cs_rise_s) begin
                        miso_r <= 1'b0;
                    end else if (sclk_rise_s) begin
                        shift_r   <= {shift_r[FRAME_WIDTH-2:0], mosi_sync_r};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end else if (sclk_fall_s) begin
                        tx_r   <= {tx_r[FRAME_WIDTH-2:0], 1'b0};
                        miso_r <= tx_r[FRAME_WIDTH-2];
                    end
                end
                ST_DONE: begin
                    cmd_r     <= shift_r[FRAME_WIDTH-1 -: CMD_BITS];
                    addr_r    <= shift_r[PAYLOAD_BITS +: ADDR_BITS];
                    payload_r <= shift_r[0 +: PAYLOAD_BITS];
                    rx_dv_r   <= 1'b1;
                    miso_r    <= 1'b0;
                end
                ST_WAIT_CS: begin
                    miso_r <= 1'b0;
                end
                default: begin
                    miso_r <= 1'b0;
                end
            endcase
        end
    end

    assign miso      = miso_r;
    assign rx_dv     = rx_dv_r;
    assign o_cmd     = cmd_r;
    assign o_addr    = addr_r;
    assign o_payload = payload_r;

`ifdef SPI_SLAVE_DEBUG_EN
    assign o_shift_reg_debug  = shift_r;
    assign o_serial_debug     = mosi_sync_r;
    assign o_bit_rx_cnt_debug = bit_cnt_r;
    assign o_debug_stage      = state_r;
`else
    assign o_shift_reg_debug  = {FRAME_WIDTH{1'b0}};
    assign o_serial_debug     = 1'b0;
    assign o_bit_rx_cnt_debug = 5'd0;
    assign o_debug_stage      = 3'd0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Self-checking bench for spi_frame_slave: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_spi_frame_slave;

    localparam int HALF = 80;

    logic        sysclk = 1'b0;
    logic        rst_n, sclk, cs, mosi, slv_tx_enb;
    logic [23:0] i_slv_frame;
    logic        miso, rx_dv, o_serial_debug;
    logic [7:0]  o_cmd, o_addr, o_payload;
    logic [23:0] o_shift_reg_debug;
    logic [4:0]  o_bit_rx_cnt_debug;
    logic [2:0]  o_debug_stage;

    int          total = 0;
    int          bad = 0;
    int          dv_cnt = 0;
    logic [23:0] dv_fields = 24'd0;
    logic [23:0] exp_fields = 24'd0;

    spi_frame_slave dut (
        .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .slv_tx_enb(slv_tx_enb), .i_slv_frame(i_slv_frame), .miso(miso),
        .o_cmd(o_cmd), .o_addr(o_addr), .o_payload(o_payload), .rx_dv(rx_dv),
        .o_shift_reg_debug(o_shift_reg_debug), .o_serial_debug(o_serial_debug),
        .o_bit_rx_cnt_debug(o_bit_rx_cnt_debug), .o_debug_stage(o_debug_stage)
    );

    always #5 sysclk = ~sysclk;

    // Count rx_dv pulses and capture the fields presented with each one
    always @(negedge sysclk) begin
        if (rx_dv) begin
            dv_cnt    <= dv_cnt + 1;
            dv_fields <= {o_cmd, o_addr, o_payload};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SPI master, mode 0: drive mosi while sclk low, sample miso on rising edges
    task automatic spi_xfer(input logic [23:0] tx, input int pulses, output logic [23:0] rx);
        rx = 24'd0;
        mosi = 1'b0;
        cs = 1'b0;
        #HALF;
        for (int i = 0; i < pulses; i++) begin
            mosi = (i < 24) ? tx[23-i] : 1'b0;
            #HALF;
            sclk = 1'b1;
            if (i < 24) rx[23-i] = miso;
            if (i == 0) begin
                slv_tx_enb  = 1'($urandom);
                i_slv_frame = 24'($urandom);
            end
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        cs = 1'b1;
        mosi = 1'b0;
        #(HALF * 2);
    endtask

    task automatic run_frame(input string tag, input logic [23:0] tx, input int pulses,
                             input logic enb, input logic [23:0] resp);
        int          dv0;
        logic [23:0] mcap;
        logic [23:0] exp_miso;
        int          exp_dv;
        slv_tx_enb  = enb;
        i_slv_frame = resp;
        exp_miso    = enb ? resp : 24'd0;
        dv0 = dv_cnt;
        spi_xfer(tx, pulses, mcap);
        if (pulses >= 24) begin
            exp_fields = tx;
            exp_dv = 1;
            check_val({tag, "_dvfields"}, 32'(dv_fields), 32'(tx));
            check_val({tag, "_miso"}, 32'(mcap), 32'(exp_miso));
        end else begin
            exp_dv = 0;
        end
        check_val({tag, "_dvcount"}, 32'(dv_cnt - dv0), 32'(exp_dv));
        check_val({tag, "_fields"}, 32'({o_cmd, o_addr, o_payload}), 32'(exp_fields));
        check_val({tag, "_miso_idle"}, 32'(miso), 32'd0);
        check_val({tag, "_stage"}, 32'(o_debug_stage), 32'd0);
`ifndef SPI_SLAVE_DEBUG_EN
        check_val({tag, "_dbg_off"}, 32'({o_shift_reg_debug, o_bit_rx_cnt_debug, o_serial_debug}), 32'd0);
`endif
    endtask

    initial begin
        logic [23:0] f, r;
        int          p;
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        slv_tx_enb = 1'b0; i_slv_frame = 24'd0;
        repeat (3) @(posedge sysclk);
        #1;
        check_val("reset_fields", 32'({o_cmd, o_addr, o_payload}), 32'd0);
        check_val("reset_dv_miso", 32'({rx_dv, miso}), 32'd0);
        check_val("reset_stage", 32'(o_debug_stage), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (5) @(posedge sysclk);

        run_frame("f81a1d1", 24'h81A1D1, 24, 1'b0, 24'hFFFFFF);
        run_frame("f01020a", 24'h01020A, 24, 1'b0, 24'h000000);
        run_frame("resp00a", 24'h010905, 24, 1'b1, 24'h00000A);
        run_frame("abort12", 24'hFFFFFF, 12, 1'b1, 24'hC3C3C3);
        run_frame("f123456", 24'h123456, 24, 1'b1, 24'h800001);

        // Reset mid-frame while miso is driving ones
        slv_tx_enb = 1'b1; i_slv_frame = 24'hFFFFFF;
        cs = 1'b0;
        #HALF;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'b1; #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
        end
        #60;
        check_val("midframe_miso", 32'(miso), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_fields", 32'({o_cmd, o_addr, o_payload}), 32'd0);
        check_val("rst_mid_dv_miso", 32'({rx_dv, miso}), 32'd0);
        check_val("rst_mid_stage", 32'(o_debug_stage), 32'd0);
        exp_fields = 24'd0;
        cs = 1'b1; mosi = 1'b0;
        #HALF;
        rst_n = 1'b1;
        #(HALF * 2);
        run_frame("fa5c33c", 24'hA5C33C, 24, 1'b0, 24'h000000);
        run_frame("extra26", 24'hABCDEF, 26, 1'b1, 24'h5A5A5A);

        for (int k = 0; k < 20; k++) begin
            f = 24'($urandom);
            r = 24'($urandom);
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : int'($urandom_range(24, 26));
            run_frame($sformatf("rnd%0d", k), f, p, 1'($urandom), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
